// File: rtl/branch_predictor.sv
// branch_predictor: bimodal/gshare PHT with a tagged BTB
// and lookup/mispredict statistics, beside the IF stage.
module branch_predictor #(
  parameter int ENTRIES   = 16,
  parameter int PC_WIDTH  = 12,
  parameter int CTR_WIDTH = 2,
  parameter int MODE      = 0,
  parameter int GHR_WIDTH = 4,
  localparam int IDX_W    = $clog2(ENTRIES)
) (
  input  logic                CLK,
  input  logic                RSTn,
  input  logic                LU_VALID,
  input  logic [PC_WIDTH-1:0] LU_PC,
  output logic                PRED_HIT,
  output logic                PRED_TAKEN,
  output logic [PC_WIDTH-1:0] PRED_TARGET,
  output logic [IDX_W-1:0]    PRED_IDX,
  input  logic                UPD_VALID,
  input  logic [PC_WIDTH-1:0] UPD_PC,
  input  logic [IDX_W-1:0]    UPD_IDX,
  input  logic                UPD_TAKEN,
  input  logic [PC_WIDTH-1:0] UPD_TARGET,
  input  logic                UPD_MISPRED,
  output logic [31:0]         NUM_LOOKUP,
  output logic [31:0]         NUM_MISPRED
);

  localparam int TAG_W = PC_WIDTH - IDX_W - 2;
  localparam logic [CTR_WIDTH-1:0] CTR_RST =
    CTR_WIDTH'((1 << (CTR_WIDTH - 1)) - 1);
  localparam logic [CTR_WIDTH-1:0] CTR_MAX = '1;

  logic [ENTRIES-1:0]   btb_vld_q, btb_vld_d;
  logic [TAG_W-1:0]     btb_tag_q [ENTRIES];
  logic [TAG_W-1:0]     btb_tag_d [ENTRIES];
  logic [PC_WIDTH-1:0]  btb_tgt_q [ENTRIES];
  logic [PC_WIDTH-1:0]  btb_tgt_d [ENTRIES];
  logic [CTR_WIDTH-1:0] pht_q [ENTRIES];
  logic [CTR_WIDTH-1:0] pht_d [ENTRIES];
  logic [GHR_WIDTH-1:0] ghr_q, ghr_d;
  logic [31:0]          num_lookup_q, num_lookup_d;
  logic [31:0]          num_mispred_q, num_mispred_d;

  logic [IDX_W-1:0] lu_bidx, upd_bidx;
  logic [TAG_W-1:0] lu_tag, upd_tag;
  logic             unused_pc_lsbs;

  assign lu_bidx  = LU_PC[IDX_W+1:2];
  assign lu_tag   = LU_PC[PC_WIDTH-1:IDX_W+2];
  assign upd_bidx = UPD_PC[IDX_W+1:2];
  assign upd_tag  = UPD_PC[PC_WIDTH-1:IDX_W+2];
  assign unused_pc_lsbs = ^{LU_PC[1:0], UPD_PC[1:0]};

  // gshare folds the zero-extended history into the low index bits
  assign PRED_IDX = (MODE == 1) ? (lu_bidx ^ IDX_W'(ghr_q))
                                : lu_bidx;

  assign PRED_HIT    = LU_VALID & btb_vld_q[lu_bidx]
                     & (btb_tag_q[lu_bidx] == lu_tag);
  assign PRED_TAKEN  = PRED_HIT & pht_q[PRED_IDX][CTR_WIDTH-1];
  assign PRED_TARGET = PRED_HIT ? btb_tgt_q[lu_bidx] : '0;
  assign NUM_LOOKUP  = num_lookup_q;
  assign NUM_MISPRED = num_mispred_q;

  always_comb begin
    btb_vld_d     = btb_vld_q;
    btb_tag_d     = btb_tag_q;
    btb_tgt_d     = btb_tgt_q;
    pht_d         = pht_q;
    ghr_d         = ghr_q;
    num_mispred_d = num_mispred_q;
    num_lookup_d  = num_lookup_q + 32'(LU_VALID);
    if (UPD_VALID) begin
      if (UPD_TAKEN) begin
        if (pht_q[UPD_IDX] != CTR_MAX)
          pht_d[UPD_IDX] = pht_q[UPD_IDX] + 1'b1;
        btb_vld_d[upd_bidx] = 1'b1;
        btb_tag_d[upd_bidx] = upd_tag;
        btb_tgt_d[upd_bidx] = UPD_TARGET;
      end else if (pht_q[UPD_IDX] != '0) begin
        pht_d[UPD_IDX] = pht_q[UPD_IDX] - 1'b1;
      end
      ghr_d         = GHR_WIDTH'({ghr_q, UPD_TAKEN});
      num_mispred_d = num_mispred_q + 32'(UPD_MISPRED);
    end
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      btb_vld_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        btb_tag_q[i] <= '0;
        btb_tgt_q[i] <= '0;
        pht_q[i]     <= CTR_RST;
      end
      ghr_q         <= '0;
      num_lookup_q  <= '0;
      num_mispred_q <= '0;
    end else begin
      btb_vld_q     <= btb_vld_d;
      btb_tag_q     <= btb_tag_d;
      btb_tgt_q     <= btb_tgt_d;
      pht_q         <= pht_d;
      ghr_q         <= ghr_d;
      num_lookup_q  <= num_lookup_d;
      num_mispred_q <= num_mispred_d;
    end
  end

endmodule

// File: tb/tb_branch_predictor.sv
// tb_branch_predictor: scoreboard bench driving a bimodal
// and a gshare instance with the same stimulus.
module tb_branch_predictor;

  localparam int PCW = 12;
  localparam int IW  = 4;

  logic           CLK = 1'b0;
  logic           RSTn;
  logic           LU_VALID, UPD_VALID, UPD_TAKEN, UPD_MISPRED;
  logic [PCW-1:0] LU_PC, UPD_PC, UPD_TARGET;
  logic [IW-1:0]  UPD_IDX;

  logic           hit_b, tkn_b, hit_g, tkn_g;
  logic [PCW-1:0] tgt_b, tgt_g;
  logic [IW-1:0]  idx_b, idx_g;
  logic [31:0]    nlu_b, nmp_b, nlu_g, nmp_g;

  typedef struct packed {
    logic           hit;
    logic           taken;
    logic [PCW-1:0] tgt;
    logic [IW-1:0]  idx;
  } exp_t;

  exp_t sb[$];
  exp_t e, obs_b, obs_g;
  int   checks = 0;
  int   errors = 0;

  assign obs_b = {hit_b, tkn_b, tgt_b, idx_b};
  assign obs_g = {hit_g, tkn_g, tgt_g, idx_g};

  always #5 CLK = ~CLK;

  branch_predictor #(.MODE(0)) u_bim (
    .CLK(CLK), .RSTn(RSTn),
    .LU_VALID(LU_VALID), .LU_PC(LU_PC),
    .PRED_HIT(hit_b), .PRED_TAKEN(tkn_b),
    .PRED_TARGET(tgt_b), .PRED_IDX(idx_b),
    .UPD_VALID(UPD_VALID), .UPD_PC(UPD_PC),
    .UPD_IDX(UPD_IDX), .UPD_TAKEN(UPD_TAKEN),
    .UPD_TARGET(UPD_TARGET), .UPD_MISPRED(UPD_MISPRED),
    .NUM_LOOKUP(nlu_b), .NUM_MISPRED(nmp_b)
  );

  branch_predictor #(.MODE(1)) u_gsh (
    .CLK(CLK), .RSTn(RSTn),
    .LU_VALID(LU_VALID), .LU_PC(LU_PC),
    .PRED_HIT(hit_g), .PRED_TAKEN(tkn_g),
    .PRED_TARGET(tgt_g), .PRED_IDX(idx_g),
    .UPD_VALID(UPD_VALID), .UPD_PC(UPD_PC),
    .UPD_IDX(UPD_IDX), .UPD_TAKEN(UPD_TAKEN),
    .UPD_TARGET(UPD_TARGET), .UPD_MISPRED(UPD_MISPRED),
    .NUM_LOOKUP(nlu_g), .NUM_MISPRED(nmp_g)
  );

  task automatic push(input logic h, input logic t,
                      input logic [PCW-1:0] tg,
                      input logic [IW-1:0] ix);
    exp_t x;
    x = {h, t, tg, ix};
    sb.push_back(x);
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic set_upd(input logic [PCW-1:0] pc,
                         input logic [IW-1:0] ix,
                         input logic t,
                         input logic [PCW-1:0] tg,
                         input logic mp);
    UPD_VALID   = 1'b1;
    UPD_PC      = pc;
    UPD_IDX     = ix;
    UPD_TAKEN   = t;
    UPD_TARGET  = tg;
    UPD_MISPRED = mp;
  endtask

  task automatic upd(input logic [PCW-1:0] pc,
                     input logic [IW-1:0] ix,
                     input logic t,
                     input logic [PCW-1:0] tg,
                     input logic mp);
    set_upd(pc, ix, t, tg, mp);
    step();
    UPD_VALID   = 1'b0;
    UPD_MISPRED = 1'b0;
  endtask

  task automatic apply_reset();
    UPD_VALID = 1'b0;
    #1 RSTn = 1'b0;
    #1;
    @(negedge CLK) RSTn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    RSTn = 1'b0;
    LU_VALID = 1'b1;
    LU_PC = 12'h040;
    UPD_VALID = 1'b0;
    UPD_MISPRED = 1'b0;
    set_upd(12'h000, 4'h0, 1'b0, 12'h000, 1'b0);
    UPD_VALID = 1'b0;
    #3;
    push(1'b0, 1'b0, 12'h000, 4'h0);
    e = sb.pop_front();
    checks++;
    if (obs_b !== e) begin
      errors++;
      $display("FAIL reset_lookup: got %h want %h", obs_b, e);
    end
    checks++;
    if (nlu_b !== 32'd0 || nmp_b !== 32'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d want 0/0",
               nlu_b, nmp_b);
    end
    @(negedge CLK) RSTn = 1'b1;
    LU_VALID = 1'b0;
    step();
  endtask

  task automatic test_training();
    apply_reset();
    LU_VALID = 1'b1;
    LU_PC = 12'h040;
    set_upd(12'h040, 4'h0, 1'b1, 12'h020, 1'b1);
    #1;
    push(1'b0, 1'b0, 12'h000, 4'h0);
    e = sb.pop_front();
    checks++;
    if (obs_b !== e) begin
      errors++;
      $display("FAIL same_cycle: got %h want %h", obs_b, e);
    end
    push(1'b1, 1'b1, 12'h020, 4'h0);
    step();
    UPD_VALID = 1'b0;
    e = sb.pop_front();
    checks++;
    if (obs_b !== e) begin
      errors++;
      $display("FAIL train_next: got %h want %h", obs_b, e);
    end
  endtask

  task automatic test_saturation();
    bit ops [11]  = '{1,1,1,1,0,0,0,0,0,1,1};
    bit want [11] = '{1,1,1,1,1,0,0,0,0,0,1};
    apply_reset();
    LU_VALID = 1'b1;
    LU_PC = 12'h040;
    for (int i = 0; i < 11; i++) begin
      push(1'b1, want[i], 12'h020, 4'h0);
      upd(12'h040, 4'h0, ops[i],
          ops[i] ? 12'h020 : 12'h3fc, 1'b0);
      e = sb.pop_front();
      checks++;
      if (obs_b !== e) begin
        errors++;
        $display("FAIL sat_step%0d: got %h want %h",
                 i, obs_b, e);
      end
    end
  endtask

  task automatic test_aliasing();
    apply_reset();
    LU_VALID = 1'b1;
    LU_PC = 12'h080;
    upd(12'h040, 4'h0, 1'b1, 12'h020, 1'b0);
    push(1'b0, 1'b0, 12'h000, 4'h0);
    push(1'b0, 1'b0, 12'h000, 4'h1);
    push(1'b1, 1'b1, 12'h020, 4'h0);
    for (int i = 0; i < 3; i++) begin
      LU_VALID = (i == 1) ? 1'b0 : 1'b1;
      LU_PC = (i == 0) ? 12'h080 :
              (i == 1) ? 12'h044 : 12'h040;
      #1;
      e = sb.pop_front();
      checks++;
      if (obs_b !== e) begin
        errors++;
        $display("FAIL alias%0d: got %h want %h",
                 i, obs_b, e);
      end
    end
  endtask

  task automatic test_gshare();
    apply_reset();
    LU_VALID = 1'b0;
    upd(12'h040, 4'h0, 1'b1, 12'h020, 1'b0);
    upd(12'h040, 4'h0, 1'b0, 12'h020, 1'b0);
    upd(12'h040, 4'h0, 1'b1, 12'h020, 1'b0);
    upd(12'h040, 4'h0, 1'b0, 12'h020, 1'b0);
    LU_VALID = 1'b1;
    LU_PC = 12'h040;
    #1;
    push(1'b1, 1'b0, 12'h020, 4'hA);
    e = sb.pop_front();
    checks++;
    if (obs_g !== e) begin
      errors++;
      $display("FAIL gshare_lookup: got %h want %h", obs_g, e);
    end
    checks++;
    if (idx_b !== 4'h0) begin
      errors++;
      $display("FAIL bimodal_idx: got %h want 0", idx_b);
    end
    LU_PC = 12'h044;
    #1;
    checks++;
    if (idx_g !== 4'hB) begin
      errors++;
      $display("FAIL gshare_idx1: got %h want b", idx_g);
    end
  endtask

  task automatic test_counters();
    LU_VALID = 1'b0;
    apply_reset();
    for (int i = 0; i < 100; i++) begin
      LU_VALID = 1'b1;
      UPD_VALID = 1'b0;
      UPD_MISPRED = 1'b0;
      if (i % 10 == 3)
        set_upd(12'h040, 4'h0, 1'b1, 12'h020, i < 70);
      else if (i % 10 == 7)
        UPD_MISPRED = 1'b1;
      step();
    end
    LU_VALID = 1'b0;
    UPD_VALID = 1'b0;
    UPD_MISPRED = 1'b0;
    step();
    checks++;
    if (nlu_b !== 32'd100 || nlu_g !== 32'd100) begin
      errors++;
      $display("FAIL num_lookup: got %0d/%0d want 100",
               nlu_b, nlu_g);
    end
    checks++;
    if (nmp_b !== 32'd7 || nmp_g !== 32'd7) begin
      errors++;
      $display("FAIL num_mispred: got %0d/%0d want 7",
               nmp_b, nmp_g);
    end
  endtask

  task automatic test_async_reset();
    LU_VALID = 1'b1;
    LU_PC = 12'h040;
    #2 RSTn = 1'b0;
    #1;
    push(1'b0, 1'b0, 12'h000, 4'h0);
    e = sb.pop_front();
    checks++;
    if (obs_b !== e) begin
      errors++;
      $display("FAIL midreset_lookup: got %h want %h", obs_b, e);
    end
    checks++;
    if (nlu_b !== 32'd0 || nmp_b !== 32'd0) begin
      errors++;
      $display("FAIL midreset_counters: got %0d/%0d want 0/0",
               nlu_b, nmp_b);
    end
    @(negedge CLK) RSTn = 1'b1;
    step();
    upd(12'h040, 4'h0, 1'b0, 12'h020, 1'b0);
    upd(12'h040, 4'h0, 1'b1, 12'h020, 1'b0);
    push(1'b1, 1'b0, 12'h020, 4'h0);
    e = sb.pop_front();
    checks++;
    if (obs_b !== e) begin
      errors++;
      $display("FAIL pht_reset_value: got %h want %h", obs_b, e);
    end
  endtask

  initial begin
    test_reset();
    test_training();
    test_saturation();
    test_aliasing();
    test_gshare();
    test_counters();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1, "timeout");
  end

endmodule
